result_stream_reader: RTL and testbench



---
 rtl/result_stream_reader.sv | 121 ++++++++++++
 tb/tb_result_stream_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_stream_reader.sv
// Drains a window of the result memory over a valid/ready stream after the
// controller signals run completion; one word per cycle without backpressure.
module result_stream_reader #(
  parameter int                ADDR_W    = 14,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              finish,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  output logic [ADDR_W-1:0] output_address,
  input  logic [DATA_W-1:0] final_output,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic                finish_q;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                start, load, done_d;

  assign start = finish & ~finish_q & (state_q == ST_IDLE);
  // The output register refills whenever it is empty or being drained this cycle.
  assign load  = (state_q == ST_STREAM) & (remaining_q != '0) & (~out_valid_q | out_ready);

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      busy_d      = 1'b0;
      rd_ptr_d    = BASE_ADDR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_d = 1'b1;
            if (word_count != '0) begin
              state_d     = ST_STREAM;
              rd_ptr_d    = BASE_ADDR;
              remaining_d = word_count;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
        ST_STREAM: begin
          if (load) begin
            out_data_d  = final_output;
            out_valid_d = 1'b1;
            out_last_d  = (remaining_q == {{ADDR_W{1'b0}}, 1'b1});
            rd_ptr_d    = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            remaining_d = remaining_q - {{ADDR_W{1'b0}}, 1'b1};
          end else if (out_valid_q & out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
          if (out_valid_q & out_ready & out_last_q) state_d = ST_DONE;
        end
        ST_DONE: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      finish_q    <= 1'b0;
      rd_ptr_q    <= BASE_ADDR;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      finish_q    <= finish;
      rd_ptr_q    <= rd_ptr_d;
      remaining_q <= remaining_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign output_address = rd_ptr_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;
  assign out_last       = out_last_q;
  assign busy           = busy_q;
  assign done           = done_d;

endmodule

// File: tb/tb_result_stream_reader.sv
// Directed bench for result_stream_reader: one instance at base 0, one at base 0x3FFE.
module tb_result_stream_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        finish0 = 1'b0, finish1 = 1'b0;
  logic [14:0] word_count = '0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;

  logic [13:0] addr0, addr1;
  logic [15:0] fo0, fo1, data0, data1;
  logic        valid0, valid1, last0, last1, busy0, busy1, done0, done1;

  logic [15:0] mem [0:16383];

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  assign fo0 = mem[addr0];
  assign fo1 = mem[addr1];

  result_stream_reader #(.ADDR_W(14), .DATA_W(16), .BASE_ADDR(14'h0000)) dut0 (
    .clock(clock), .reset(reset), .finish(finish0), .word_count(word_count),
    .abort(abort), .output_address(addr0), .final_output(fo0), .out_data(data0),
    .out_valid(valid0), .out_ready(out_ready), .out_last(last0), .busy(busy0), .done(done0)
  );

  result_stream_reader #(.ADDR_W(14), .DATA_W(16), .BASE_ADDR(14'h3FFE)) dut1 (
    .clock(clock), .reset(reset), .finish(finish1), .word_count(word_count),
    .abort(abort), .output_address(addr1), .final_output(fo1), .out_data(data1),
    .out_valid(valid1), .out_ready(out_ready), .out_last(last1), .busy(busy1), .done(done1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if (addr0 !== 14'h0000) begin errors++; $display("FAIL reset_addr0: got %h expected 0000", addr0); end
    checks++; if (addr1 !== 14'h3FFE) begin errors++; $display("FAIL reset_addr1: got %h expected 3ffe", addr1); end
    checks++; if (data0 !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", data0); end
    checks++; if ({valid0, last0, busy0, done0} !== 4'b0000) begin errors++; $display("FAIL reset_ctrl: got %b expected 0000", {valid0, last0, busy0, done0}); end
    reset = 1'b1;
    tick();
    checks++; if ({valid0, busy0, done0} !== 3'b000) begin errors++; $display("FAIL reset_release: got %b expected 000", {valid0, busy0, done0}); end
  endtask

  task automatic test_basic();
    logic exp_last;
    word_count = 15'd4; out_ready = 1'b1; finish0 = 1'b1;
    tick(); finish0 = 1'b0;
    checks++; if (busy0 !== 1'b1 || valid0 !== 1'b0) begin errors++; $display("FAIL basic_start: busy=%b valid=%b expected busy=1 valid=0", busy0, valid0); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_last = (i == 3);
      checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL basic_valid%0d: got %b expected 1", i, valid0); end
      checks++; if (data0 !== 16'h1000 + 16'(i)) begin errors++; $display("FAIL basic_data%0d: got %h expected %h", i, data0, 16'h1000 + 16'(i)); end
      checks++; if (last0 !== exp_last) begin errors++; $display("FAIL basic_last%0d: got %b expected %b", i, last0, exp_last); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_early_done%0d: got %b expected 0", i, done0); end
    end
    tick();
    checks++; if ({done0, valid0, busy0} !== 3'b101) begin errors++; $display("FAIL basic_done: done,valid,busy got %b expected 101", {done0, valid0, busy0}); end
    tick();
    checks++; if ({done0, busy0} !== 2'b00) begin errors++; $display("FAIL basic_idle: done,busy got %b expected 00", {done0, busy0}); end
  endtask

  task automatic test_backpressure();
    logic [6:0]  pat;
    logic [15:0] held_data;
    logic        held, exp_done, exp_last;
    int          hs, done_cnt;
    pat = 7'b1011001;
    hs = 0; done_cnt = 0; held = 1'b0; exp_done = 1'b0; held_data = '0;
    word_count = 15'd4; finish0 = 1'b1;
    tick(); finish0 = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      out_ready = (cyc < 7) ? pat[cyc] : 1'b1;
      checks++; if (done0 !== exp_done) begin errors++; $display("FAIL bp_done_c%0d: got %b expected %b", cyc, done0, exp_done); end
      if (done0) done_cnt++;
      exp_done = 1'b0;
      if (held) begin
        checks++; if (data0 !== held_data) begin errors++; $display("FAIL bp_hold_c%0d: got %h expected %h", cyc, data0, held_data); end
      end
      if (valid0 && out_ready) begin
        exp_last = (hs == 3);
        checks++; if (data0 !== 16'h1000 + 16'(hs)) begin errors++; $display("FAIL bp_data%0d: got %h expected %h", hs, data0, 16'h1000 + 16'(hs)); end
        checks++; if (last0 !== exp_last) begin errors++; $display("FAIL bp_last%0d: got %b expected %b", hs, last0, exp_last); end
        hs++;
        if (hs == 4) exp_done = 1'b1;
      end
      held = valid0 && !out_ready;
      held_data = data0;
      if (done_cnt != 0) break;
      tick();
    end
    out_ready = 1'b1;
    checks++; if (hs != 4) begin errors++; $display("FAIL bp_handshakes: got %0d expected 4", hs); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d expected 1", done_cnt); end
    tick();
  endtask

  task automatic test_zero_count();
    int done_cnt;
    done_cnt = 0;
    word_count = 15'd0; out_ready = 1'b1; finish0 = 1'b1;
    tick(); finish0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL zero_valid_c%0d: got %b expected 0", c, valid0); end
      checks++; if (busy0 !== done0) begin errors++; $display("FAIL zero_busy_c%0d: busy=%b done=%b expected equal", c, busy0, done0); end
      if (done0 === 1'b1) done_cnt++;
      tick();
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_wrap();
    logic [13:0] wa [4];
    logic [15:0] wd [4];
    int          done_cnt;
    wa = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
    wd = '{16'h4FFE, 16'h4FFF, 16'h1000, 16'h1001};
    done_cnt = 0;
    word_count = 15'd4; out_ready = 1'b1; finish1 = 1'b1;
    tick(); finish1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (addr1 !== wa[i]) begin errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, addr1, wa[i]); end
      tick();
      checks++; if (valid1 !== 1'b1 || data1 !== wd[i]) begin errors++; $display("FAIL wrap_data%0d: valid=%b data=%h expected valid=1 data=%h", i, valid1, data1, wd[i]); end
    end
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done1 === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_finish_held();
    int hs, done_cnt;
    hs = 0; done_cnt = 0;
    word_count = 15'd2; out_ready = 1'b1; finish0 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (valid0 && out_ready) begin
        checks++; if (data0 !== 16'h1000 + 16'(hs % 2)) begin errors++; $display("FAIL held_data%0d: got %h expected %h", hs, data0, 16'h1000 + 16'(hs % 2)); end
        hs++;
      end
      if (done0 === 1'b1) done_cnt++;
    end
    checks++; if (hs != 2) begin errors++; $display("FAIL held_beats: got %0d expected 2", hs); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL held_done_count: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_restart();
    int hs, done_cnt;
    hs = 0; done_cnt = 0;
    finish0 = 1'b0;
    tick();
    finish0 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (valid0 && out_ready) begin
        checks++; if (data0 !== 16'h1000 + 16'(hs % 2)) begin errors++; $display("FAIL restart_data%0d: got %h expected %h", hs, data0, 16'h1000 + 16'(hs % 2)); end
        hs++;
      end
      if (done0 === 1'b1) done_cnt++;
    end
    finish0 = 1'b0;
    checks++; if (hs != 2) begin errors++; $display("FAIL restart_beats: got %0d expected 2", hs); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", done_cnt); end
    tick();
  endtask

  task automatic test_abort();
    int done_cnt;
    done_cnt = 0;
    word_count = 15'd8; out_ready = 1'b1; finish0 = 1'b1;
    tick(); finish0 = 1'b0;
    tick();
    checks++; if (data0 !== 16'h1000) begin errors++; $display("FAIL abort_beat0: got %h expected 1000", data0); end
    tick();
    checks++; if (data0 !== 16'h1001) begin errors++; $display("FAIL abort_beat1: got %h expected 1001", data0); end
    abort = 1'b1;
    tick(); abort = 1'b0;
    checks++; if ({valid0, last0, busy0, done0} !== 4'b0000) begin errors++; $display("FAIL abort_ctrl: got %b expected 0000", {valid0, last0, busy0, done0}); end
    checks++; if (addr0 !== 14'h0000) begin errors++; $display("FAIL abort_addr: got %h expected 0000", addr0); end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done0 === 1'b1 || valid0 === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", done_cnt); end
    finish0 = 1'b1;
    tick(); finish0 = 1'b0;
    tick();
    checks++; if (valid0 !== 1'b1 || data0 !== 16'h1000) begin errors++; $display("FAIL abort_restart: valid=%b data=%h expected valid=1 data=1000", valid0, data0); end
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done0 === 1'b1) done_cnt++;
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL abort_restart_done: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    word_count = 15'd8; out_ready = 1'b1; finish0 = 1'b1;
    tick(); finish0 = 1'b0;
    tick(); tick();
    #3 reset = 1'b0;
    #1;
    checks++; if ({valid0, last0, busy0, done0} !== 4'b0000) begin errors++; $display("FAIL rstmid_ctrl: got %b expected 0000", {valid0, last0, busy0, done0}); end
    checks++; if (data0 !== 16'h0000 || addr0 !== 14'h0000) begin errors++; $display("FAIL rstmid_data: data=%h addr=%h expected 0000/0000", data0, addr0); end
    tick();
    reset = 1'b1;
    tick(); tick();
    checks++; if ({valid0, busy0} !== 2'b00) begin errors++; $display("FAIL rstmid_norestart: valid,busy got %b expected 00", {valid0, busy0}); end
  endtask

  initial begin
    for (int a = 0; a < 16384; a++) mem[a] = 16'h1000 + 16'(a);
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_count();
    test_wrap();
    test_finish_held();
    test_restart();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
